// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU control path: opcodes, T-state
// encodings and the active-high control-word layout.
package cpu_pkg;

    localparam int unsigned OPCODE_WIDTH = 4;
    localparam int unsigned STEP_WIDTH   = 3;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [2:0] T0 = 3'd0;
    localparam logic [2:0] T1 = 3'd1;
    localparam logic [2:0] T2 = 3'd2;
    localparam logic [2:0] T3 = 3'd3;
    localparam logic [2:0] T4 = 3'd4;

    // Control word in active-high form; polarity is applied at the top-level ports.
    typedef struct packed {
        logic co;
        logic ce;
        logic j;
        logic mi;
        logic ro;
        logic ri;
        logic ii;
        logic io;
        logic ai;
        logic ao;
        logic bi;
        logic eo;
        logic su;
        logic fi;
        logic oi;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '0;

    // Final T-state of each instruction; everything not listed is a 3-cycle op.
    function automatic logic [2:0] last_step(input logic [3:0] op);
        logic [2:0] s;
        case (op)
            OP_LDA, OP_STA: s = T3;
            OP_ADD, OP_SUB: s = T4;
            default:        s = T2;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/step_counter.sv
// T-state counter: advances each cycle, returns to T0 on END or from any
// unreachable encoding, and freezes while HOLD is asserted.
module step_counter
    import cpu_pkg::*;
(
    input  logic                  i_CLOCK,
    input  logic                  i_CLEAR,
    input  logic                  i_END,
    input  logic                  i_HOLD,
    output logic [STEP_WIDTH-1:0] o_STEP
);

    logic [STEP_WIDTH-1:0] step_q;
    logic [STEP_WIDTH-1:0] step_d;

    always_comb begin
        step_d = step_q;
        if (i_HOLD) begin
            step_d = step_q;
        end else if (i_END || (step_q > T4)) begin
            step_d = T0;
        end else begin
            step_d = step_q + STEP_WIDTH'(1);
        end
    end

    always_ff @(posedge i_CLOCK) begin
        if (i_CLEAR) begin
            step_q <= T0;
        end else begin
            step_q <= step_d;
        end
    end

    assign o_STEP = step_q;

endmodule

// File: rtl/control_sequencer.sv
// Microcoded control unit: halt latch plus decode of (step, opcode, flags)
// into the CPU's bus and register control lines.
module control_sequencer #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned OPCODE_WIDTH = cpu_pkg::OPCODE_WIDTH
) (
    input  logic                  i_CLOCK,
    input  logic                  i_CLEAR,
    input  logic [DATA_WIDTH-1:0] i_INSTRUCTION,
    input  logic                  i_ZERO_FLAG,
    input  logic                  i_CARRY_FLAG,
    output logic                  o_CO_n,
    output logic                  o_CE,
    output logic                  o_J_n,
    output logic                  o_MI_n,
    output logic                  o_RO_n,
    output logic                  o_RI_n,
    output logic                  o_II_n,
    output logic                  o_IO_n,
    output logic                  o_AI_n,
    output logic                  o_AO_n,
    output logic                  o_BI_n,
    output logic                  o_EO_n,
    output logic                  o_SU,
    output logic                  o_FI_n,
    output logic                  o_OI_n,
    output logic                  o_HALT,
    output logic [2:0]            o_STEP
);

    import cpu_pkg::*;

    logic [OPCODE_WIDTH-1:0] opcode_c;
    logic [STEP_WIDTH-1:0]   step_q;
    logic                    halt_q;
    logic                    halt_d;
    logic                    end_c;
    ctrl_t                   ucode_c;
    ctrl_t                   ctrl_c;
    logic                    unused_operand_c;

    assign opcode_c         = i_INSTRUCTION[DATA_WIDTH-1 -: OPCODE_WIDTH];
    assign unused_operand_c = ^i_INSTRUCTION[DATA_WIDTH-OPCODE_WIDTH-1:0];

    step_counter u_step_counter (
        .i_CLOCK (i_CLOCK),
        .i_CLEAR (i_CLEAR),
        .i_END   (end_c),
        .i_HOLD  (halt_q),
        .o_STEP  (step_q)
    );

    // Microcode table; the opcode is only consulted from T2 onward.
    always_comb begin
        ucode_c = CTRL_IDLE;
        halt_d  = halt_q;
        end_c   = 1'b0;
        case (step_q)
            T0: begin
                ucode_c.co = 1'b1;
                ucode_c.mi = 1'b1;
            end
            T1: begin
                ucode_c.ro = 1'b1;
                ucode_c.ii = 1'b1;
                ucode_c.ce = 1'b1;
            end
            T2: begin
                end_c = (last_step(opcode_c) == T2);
                case (opcode_c)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        ucode_c.io = 1'b1;
                        ucode_c.mi = 1'b1;
                    end
                    OP_LDI: begin
                        ucode_c.io = 1'b1;
                        ucode_c.ai = 1'b1;
                    end
                    OP_JMP: begin
                        ucode_c.io = 1'b1;
                        ucode_c.j  = 1'b1;
                    end
                    OP_JC: begin
                        ucode_c.io = i_CARRY_FLAG;
                        ucode_c.j  = i_CARRY_FLAG;
                    end
                    OP_JZ: begin
                        ucode_c.io = i_ZERO_FLAG;
                        ucode_c.j  = i_ZERO_FLAG;
                    end
                    OP_OUT: begin
                        ucode_c.ao = 1'b1;
                        ucode_c.oi = 1'b1;
                    end
                    OP_HLT: begin
                        halt_d = 1'b1;
                    end
                    default: begin
                        ucode_c = CTRL_IDLE;
                    end
                endcase
            end
            T3: begin
                end_c = (last_step(opcode_c) == T3);
                case (opcode_c)
                    OP_LDA: begin
                        ucode_c.ro = 1'b1;
                        ucode_c.ai = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        ucode_c.ro = 1'b1;
                        ucode_c.bi = 1'b1;
                    end
                    OP_STA: begin
                        ucode_c.ao = 1'b1;
                        ucode_c.ri = 1'b1;
                    end
                    default: begin
                        ucode_c = CTRL_IDLE;
                    end
                endcase
            end
            T4: begin
                end_c = 1'b1;
                if ((opcode_c == OP_ADD) || (opcode_c == OP_SUB)) begin
                    ucode_c.eo = 1'b1;
                    ucode_c.ai = 1'b1;
                    ucode_c.fi = 1'b1;
                    ucode_c.su = (opcode_c == OP_SUB);
                end
            end
            default: begin
                ucode_c = CTRL_IDLE;
            end
        endcase
    end

    // Reset and halt both silence every control line.
    always_comb begin
        ctrl_c = ucode_c;
        if (i_CLEAR || halt_q) begin
            ctrl_c = CTRL_IDLE;
        end
    end

    always_ff @(posedge i_CLOCK) begin
        if (i_CLEAR) begin
            halt_q <= 1'b0;
        end else begin
            halt_q <= halt_d;
        end
    end

    assign o_CO_n = ~ctrl_c.co;
    assign o_CE   =  ctrl_c.ce;
    assign o_J_n  = ~ctrl_c.j;
    assign o_MI_n = ~ctrl_c.mi;
    assign o_RO_n = ~ctrl_c.ro;
    assign o_RI_n = ~ctrl_c.ri;
    assign o_II_n = ~ctrl_c.ii;
    assign o_IO_n = ~ctrl_c.io;
    assign o_AI_n = ~ctrl_c.ai;
    assign o_AO_n = ~ctrl_c.ao;
    assign o_BI_n = ~ctrl_c.bi;
    assign o_EO_n = ~ctrl_c.eo;
    assign o_SU   =  ctrl_c.su;
    assign o_FI_n = ~ctrl_c.fi;
    assign o_OI_n = ~ctrl_c.oi;
    assign o_HALT = halt_q & ~i_CLEAR;
    assign o_STEP = step_q;

endmodule
